// File: rtl/alu_mux_datapath_if.sv
// Operand, control and result bundle of the execute-stage ALU slice.
// Flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_mux_datapath_if #(
   parameter int unsigned WIDTH = 64
);
   logic [WIDTH-1:0] c_imm;
   logic [WIDTH-1:0] ra_data;
   logic [WIDTH-1:0] rb_data;
   logic [WIDTH-1:0] mem_dout;
   logic             sel_mux;
   logic             sub;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] wb_data;
   logic [WIDTH-1:0] res_q;
`ifdef ALU_FLAGS_EN
   logic             zero_q;
   logic             neg_q;
   logic             ovf_q;
`endif

   modport master (
      output c_imm, ra_data, rb_data, mem_dout, sel_mux, sub,
`ifdef ALU_FLAGS_EN
      input  zero_q, neg_q, ovf_q,
`endif
      input  alu_res, wb_data, res_q
   );

   modport slave (
      input  c_imm, ra_data, rb_data, mem_dout, sel_mux, sub,
`ifdef ALU_FLAGS_EN
      output zero_q, neg_q, ovf_q,
`endif
      output alu_res, wb_data, res_q
   );
endinterface

// File: rtl/alu_mux_datapath.sv
// Execute-stage add/sub slice with operand and write-back muxes plus a registered result.
// Define ALU_FLAGS_EN to add registered zero/negative/overflow flags.
module alu_mux_datapath #(
   parameter int unsigned WIDTH = 64
) (
   input logic               clk,
   input logic               rst_n,
   alu_mux_datapath_if.slave bus
);
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH-1:0] res_q;

   // One select steers both the operand-B mux and the write-back mux.
   always_comb begin
      op_b    = bus.sel_mux ? bus.rb_data : bus.c_imm;
      alu_res = bus.sub ? (bus.ra_data - op_b) : (bus.ra_data + op_b);
   end

   assign bus.alu_res = alu_res;
   assign bus.wb_data = bus.sel_mux ? alu_res : bus.mem_dout;
   assign bus.res_q   = res_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else begin
         res_q <= alu_res;
      end
   end

`ifdef ALU_FLAGS_EN
   logic zero_d, neg_d, ovf_d;
   logic zero_q, neg_q, ovf_q;
   logic sign_a, sign_b, sign_r;

   // Subtract overflows when operand signs differ; add when they match.
   always_comb begin
      sign_a = bus.ra_data[WIDTH-1];
      sign_b = op_b[WIDTH-1];
      sign_r = alu_res[WIDTH-1];
      zero_d = (alu_res == '0);
      neg_d  = sign_r;
      ovf_d  = bus.sub ? ((sign_a != sign_b) && (sign_r != sign_a))
                       : ((sign_a == sign_b) && (sign_r != sign_a));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         neg_q  <= neg_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.zero_q = zero_q;
   assign bus.neg_q  = neg_q;
   assign bus.ovf_q  = ovf_q;
`endif
endmodule

// File: tb/tb_alu_mux_datapath.sv
// Randomised self-checking bench for alu_mux_datapath against a wide-integer reference model.
module tb_alu_mux_datapath;
   localparam int unsigned WIDTH = 64;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   alu_mux_datapath_if #(.WIDTH(WIDTH)) bus ();

   alu_mux_datapath #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Reference: exact signed arithmetic in 128 bits, result truncated, overflow = out of range.
   task automatic model(input logic [63:0] a, b, c, m, input logic sel, s,
                        output logic [63:0] res, wb, output logic z, n, o);
      logic signed [127:0] sa, sb, ex;
      logic signed [127:0] max_v, min_v;
      sa    = $signed(a);
      sb    = sel ? $signed(b) : $signed(c);
      ex    = s ? (sa - sb) : (sa + sb);
      max_v = 128'sh7FFF_FFFF_FFFF_FFFF;
      min_v = -128'sh8000_0000_0000_0000;
      res   = ex[63:0];
      wb    = sel ? res : m;
      z     = (res == 64'd0);
      n     = ($signed(res) < 0);
      o     = (ex > max_v) || (ex < min_v);
   endtask

   logic [63:0] e_res, e_wb;
   logic        e_z, e_n, e_o;

   // Drive after a falling edge, check combinational outputs, then the registered copy.
   task automatic apply(input logic [63:0] a, b, c, m, input logic sel, s, input string tag);
      @(negedge clk);
      bus.ra_data  = a;
      bus.rb_data  = b;
      bus.c_imm    = c;
      bus.mem_dout = m;
      bus.sel_mux  = sel;
      bus.sub      = s;
      model(a, b, c, m, sel, s, e_res, e_wb, e_z, e_n, e_o);
      #1;
      check({tag, ".alu_res"}, bus.alu_res, e_res);
      check({tag, ".wb_data"}, bus.wb_data, e_wb);
      @(posedge clk);
      #1;
      check({tag, ".res_q"}, bus.res_q, e_res);
`ifdef ALU_FLAGS_EN
      check({tag, ".zero_q"}, {63'd0, bus.zero_q}, {63'd0, e_z});
      check({tag, ".neg_q"},  {63'd0, bus.neg_q},  {63'd0, e_n});
      check({tag, ".ovf_q"},  {63'd0, bus.ovf_q},  {63'd0, e_o});
`endif
   endtask

   function automatic logic [63:0] rnd64();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0: v = 64'h7FFF_FFFF_FFFF_FFFF;
         1: v = 64'h8000_0000_0000_0000;
         2: v = 64'(($urandom_range(0, 2)) - 1);
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      rst_n        = 1'b1;
      bus.ra_data  = '0;
      bus.rb_data  = '0;
      bus.c_imm    = '0;
      bus.mem_dout = '0;
      bus.sel_mux  = 1'b0;
      bus.sub      = 1'b0;
      #1 rst_n = 1'b0;
      #1 check("reset.res_q", bus.res_q, 64'd0);
      @(posedge clk);
      #1 check("reset_held.res_q", bus.res_q, 64'd0);
`ifdef ALU_FLAGS_EN
      check("reset.zero_q", {63'd0, bus.zero_q}, 64'd0);
      check("reset.neg_q",  {63'd0, bus.neg_q},  64'd0);
      check("reset.ovf_q",  {63'd0, bus.ovf_q},  64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Directed scenarios
      apply(64'd0, 64'd0, 64'd1, 64'hAB, 1'b0, 1'b0, "load_addr");
      check("load_addr.lit", e_res, 64'd1);
      apply(64'd5, 64'd7, 64'd0, 64'd0, 1'b1, 1'b0, "reg_add");
      apply(64'd3, 64'd5, 64'd0, 64'd0, 1'b1, 1'b1, "reg_sub_neg");
      apply(64'd5, 64'd5, 64'd0, 64'd0, 1'b1, 1'b1, "reg_sub_zero");
      apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 1'b1, 1'b0, "ovf_add");
      apply(64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'd0, 1'b1, 1'b1, "ovf_sub");
      apply(64'd10, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h1234, 1'b0, 1'b0, "neg_imm");

      // Asynchronous reset between edges after res_q=12
      apply(64'd5, 64'd7, 64'd0, 64'd0, 1'b1, 1'b0, "pre_reset");
      #2 rst_n = 1'b0;
      #1;
      check("async_rst.res_q", bus.res_q, 64'd0);
      check("async_rst.alu_res", bus.alu_res, 64'd12);
`ifdef ALU_FLAGS_EN
      check("async_rst.flags", {61'd0, bus.zero_q, bus.neg_q, bus.ovf_q}, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("post_rst.res_q", bus.res_q, 64'd12);

      // Control change between edges: registered value follows the final setting
      @(negedge clk);
      bus.sub = 1'b1;
      #1 check("mid_sub.alu_res", bus.alu_res, 64'hFFFF_FFFF_FFFF_FFFE);
      bus.sel_mux = 1'b0;
      bus.c_imm   = 64'd2;
      bus.mem_dout = 64'h55;
      #1 check("mid_sel.wb_data", bus.wb_data, 64'h55);
      @(posedge clk);
      #1 check("mid_sel.res_q", bus.res_q, 64'd3);

      // Randomised sweep
      for (int i = 0; i < 300; i++) begin
         apply(rnd64(), rnd64(), rnd64(), rnd64(), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
